par_sum_tree_acc: RTL and testbench

- Parametrised, pipelined adder tree that reduces PHASES parallel signed samples to one sum per clock.
- Optional per-stage halving keeps the tree output at DATA_W bits.
- A post-tree windowed accumulator sums ACC_LEN consecutive valid tree outputs, e.g. the correlation window of the packet detector.
- Sits between the parallel-phase correlator products and the detection threshold logic.

---
 rtl/par_sum_tree_acc.sv | 159 +++++++++++++++
 tb/tb_par_sum_tree_acc.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/par_sum_tree_acc.sv
// Pipelined signed adder tree reducing PHASES samples per clock, followed by a windowed accumulator.
// Optional build macro SUM_TREE_SAT_EN: saturating output format plus a sat_o flag.
module par_sum_tree_acc #(
  parameter int unsigned DATA_W           = 16,
  parameter int unsigned PHASES           = 16,
  parameter int unsigned SCALE_EACH_STAGE = 0,
  parameter int unsigned ACC_LEN          = 16,
  parameter int unsigned OUT_W            = 24
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       in_valid_i,
  input  logic [PHASES*DATA_W-1:0]   data_i,
  input  logic                       clear_i,
  output logic signed [OUT_W-1:0]    sum_o,
  output logic                       valid_o
`ifdef SUM_TREE_SAT_EN
  ,
  output logic                       sat_o
`endif
);

  localparam int unsigned LOG    = (PHASES <= 2) ? 1 : $clog2(PHASES);
  localparam int unsigned NPAD   = 1 << LOG;
  localparam int unsigned TREE_W = (SCALE_EACH_STAGE != 0) ? DATA_W : DATA_W + LOG;
  localparam int unsigned ACC_W  = TREE_W + $clog2(ACC_LEN);
  localparam int unsigned CNT_W  = (ACC_LEN <= 2) ? 1 : $clog2(ACC_LEN);

  // Heap layout: nodes 1..NPAD-1 are registers (root = 1), NPAD..2*NPAD-1 are input leaves.
  logic signed [TREE_W-1:0] node_c [1:2*NPAD-1];
  logic signed [TREE_W-1:0] tree_d [1:NPAD-1];
  logic signed [TREE_W-1:0] tree_q [1:NPAD-1];
  logic [LOG-1:0]           vld_d, vld_q;

  function automatic logic signed [TREE_W-1:0] add_node(input logic signed [TREE_W-1:0] a,
                                                        input logic signed [TREE_W-1:0] b);
    logic signed [TREE_W:0] s;
    s = (TREE_W+1)'(a) + (TREE_W+1)'(b);
    if (SCALE_EACH_STAGE != 0) s = s >>> 1;
    return TREE_W'(s);
  endfunction

  always_comb begin
    for (int unsigned n = 1; n < 2*NPAD; n++) begin
      if (n < NPAD)                 node_c[n] = tree_q[n];
      else if (n - NPAD < PHASES)   node_c[n] = TREE_W'($signed(data_i[(n-NPAD)*DATA_W +: DATA_W]));
      else                          node_c[n] = '0;
    end
  end

  always_comb begin
    for (int unsigned n = 1; n < NPAD; n++) begin
      tree_d[n] = add_node(node_c[2*n], node_c[2*n+1]);
    end
  end

  // Clear also drops any sample arriving in the same cycle.
  assign vld_d = clear_i ? '0 : LOG'({vld_q, in_valid_i});

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned n = 1; n < NPAD; n++) tree_q[n] <= '0;
      vld_q <= '0;
    end else begin
      for (int unsigned n = 1; n < NPAD; n++) tree_q[n] <= tree_d[n];
      vld_q <= vld_d;
    end
  end

  logic                     tree_vld;
  logic signed [ACC_W-1:0]  acc_d, acc_q, acc_sum;
  logic [CNT_W-1:0]         cnt_d, cnt_q;
  logic signed [OUT_W-1:0]  sum_d, sum_q, fmt_c;
  logic                     valid_d, valid_q;

  assign tree_vld = vld_q[LOG-1];
  assign acc_sum  = acc_q + ACC_W'(tree_q[1]);

`ifdef SUM_TREE_SAT_EN
  logic clip_c, sat_d, sat_q;
`endif

  generate
    if (OUT_W >= ACC_W) begin : g_ext
      assign fmt_c = OUT_W'(acc_sum);
`ifdef SUM_TREE_SAT_EN
      assign clip_c = 1'b0;
`endif
    end else begin : g_narrow
`ifdef SUM_TREE_SAT_EN
      localparam logic signed [ACC_W-1:0] SAT_HI = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
      localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;
      logic hi_c, lo_c;
      assign hi_c   = acc_sum > SAT_HI;
      assign lo_c   = acc_sum < SAT_LO;
      assign clip_c = hi_c | lo_c;
      assign fmt_c  = hi_c ? {1'b0, {(OUT_W-1){1'b1}}} :
                      lo_c ? {1'b1, {(OUT_W-1){1'b0}}} : acc_sum[OUT_W-1:0];
`else
      assign fmt_c = acc_sum[OUT_W-1:0];
`endif
    end
  endgenerate

  // Window accumulator: clear has priority over a completing tree output.
  always_comb begin
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    valid_d = 1'b0;
`ifdef SUM_TREE_SAT_EN
    sat_d   = 1'b0;
`endif
    if (clear_i) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (tree_vld) begin
      if (cnt_q == CNT_W'(ACC_LEN-1)) begin
        sum_d   = fmt_c;
        valid_d = 1'b1;
        acc_d   = '0;
        cnt_d   = '0;
`ifdef SUM_TREE_SAT_EN
        sat_d   = clip_c;
`endif
      end else begin
        acc_d = acc_sum;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      valid_q <= 1'b0;
`ifdef SUM_TREE_SAT_EN
      sat_q   <= 1'b0;
`endif
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      valid_q <= valid_d;
`ifdef SUM_TREE_SAT_EN
      sat_q   <= sat_d;
`endif
    end
  end

  assign sum_o   = sum_q;
  assign valid_o = valid_q;
`ifdef SUM_TREE_SAT_EN
  assign sat_o   = sat_q;
`endif

endmodule

// File: tb/tb_par_sum_tree_acc.sv
// Directed bench for par_sum_tree_acc: four parameterisations sharing clock, reset, valid and clear.
module tb_par_sum_tree_acc;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic               rst_ni, in_valid_i, clear_i;
  logic [16*16-1:0]   data16;
  logic [5*16-1:0]    data5;
  logic signed [23:0] sum_a, sum_b, sum_c;
  logic signed [15:0] sum_d;
  logic               valid_a, valid_b, valid_c, valid_d;
`ifdef SUM_TREE_SAT_EN
  logic               sat_a, sat_b, sat_c, sat_d;
`endif

  int checks = 0;
  int errors = 0;

  par_sum_tree_acc #(.DATA_W(16), .PHASES(16), .SCALE_EACH_STAGE(0), .ACC_LEN(4), .OUT_W(24)) u_a (
    .clk_i(clk_i), .rst_ni(rst_ni), .in_valid_i(in_valid_i), .data_i(data16), .clear_i(clear_i),
    .sum_o(sum_a), .valid_o(valid_a)
`ifdef SUM_TREE_SAT_EN
    , .sat_o(sat_a)
`endif
  );

  par_sum_tree_acc #(.DATA_W(16), .PHASES(16), .SCALE_EACH_STAGE(1), .ACC_LEN(1), .OUT_W(24)) u_b (
    .clk_i(clk_i), .rst_ni(rst_ni), .in_valid_i(in_valid_i), .data_i(data16), .clear_i(clear_i),
    .sum_o(sum_b), .valid_o(valid_b)
`ifdef SUM_TREE_SAT_EN
    , .sat_o(sat_b)
`endif
  );

  par_sum_tree_acc #(.DATA_W(16), .PHASES(5), .SCALE_EACH_STAGE(0), .ACC_LEN(1), .OUT_W(24)) u_c (
    .clk_i(clk_i), .rst_ni(rst_ni), .in_valid_i(in_valid_i), .data_i(data5), .clear_i(clear_i),
    .sum_o(sum_c), .valid_o(valid_c)
`ifdef SUM_TREE_SAT_EN
    , .sat_o(sat_c)
`endif
  );

  par_sum_tree_acc #(.DATA_W(16), .PHASES(16), .SCALE_EACH_STAGE(0), .ACC_LEN(4), .OUT_W(16)) u_d (
    .clk_i(clk_i), .rst_ni(rst_ni), .in_valid_i(in_valid_i), .data_i(data16), .clear_i(clear_i),
    .sum_o(sum_d), .valid_o(valid_d)
`ifdef SUM_TREE_SAT_EN
    , .sat_o(sat_d)
`endif
  );

  task automatic check_eq(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_all(input logic [15:0] v);
    for (int p = 0; p < 16; p++) data16[p*16 +: 16] = v;
  endtask

  task automatic idle_clear();
    in_valid_i = 1'b0;
    clear_i    = 1'b1;
    step();
    clear_i    = 1'b0;
    step();
  endtask

  logic [6:0] gap_pat;

  initial begin
    rst_ni     = 1'b1;
    in_valid_i = 1'b0;
    clear_i    = 1'b0;
    data16     = '0;
    data5      = '0;
    gap_pat    = 7'b1100101;
    #2 rst_ni  = 1'b0;
    step();
    step();
    check_eq("rst_sum_a", sum_a, 0);
    check_eq("rst_sum_b", sum_b, 0);
    check_eq("rst_sum_c", sum_c, 0);
    check_eq("rst_sum_d", sum_d, 0);
    check_eq("rst_valid_a", valid_a, 0);
    check_eq("rst_valid_b", valid_b, 0);
    rst_ni = 1'b1;
    step();
    step();

    // Four vectors of 1000s, window of 4: 16 * 1000 * 4 at t=8.
    set_all(16'd1000);
    for (int c = 0; c < 10; c++) begin
      in_valid_i = (c < 4);
      step();
      check_eq("win4_valid", valid_a, (c + 1 == 8));
      if (c + 1 == 8) check_eq("win4_sum", sum_a, 64000);
    end
    idle_clear();

    // Scaled tree, no accumulation: 1000s then alternating -1/0 (floors to -1).
    for (int c = 0; c < 20; c++) begin
      if (c < 10) set_all(16'd1000);
      else for (int p = 0; p < 16; p++) data16[p*16 +: 16] = (p % 2 == 0) ? 16'hFFFF : 16'h0000;
      in_valid_i = 1'b1;
      step();
      check_eq("scale_valid", valid_b, (c + 1 >= 5));
      if (c + 1 >= 5) check_eq("scale_sum", sum_b, (c - 4 >= 10) ? -1 : 1000);
    end
    idle_clear();

    // Five phases padded to eight: 1+2+3+4+5 after LOG+1 = 4 cycles.
    data5 = {16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
    for (int c = 0; c < 7; c++) begin
      in_valid_i = (c == 0);
      step();
      check_eq("pad5_valid", valid_c, (c + 1 == 4));
      if (c + 1 == 4) check_eq("pad5_sum", sum_c, 15);
    end
    idle_clear();

    // Gappy valid: fourth valid at c=6, output 5 cycles later.
    data16 = '0;
    data16[15:0] = 16'd10;
    for (int c = 0; c < 14; c++) begin
      in_valid_i = (c < 7) ? gap_pat[c] : 1'b0;
      step();
      check_eq("gap_valid", valid_a, (c + 1 == 11));
      if (c + 1 == 11) check_eq("gap_sum", sum_a, 40);
    end
    idle_clear();

    // Clear mid-window together with a valid input; sum_o holds the previous window.
    data16[15:0] = 16'd7;
    for (int c = 0; c < 14; c++) begin
      in_valid_i = (c < 7);
      clear_i    = (c == 2);
      step();
      check_eq("clr_valid", valid_a, (c + 1 == 11));
      if (c + 1 == 3)  check_eq("clr_hold_sum", sum_a, 40);
      if (c + 1 == 11) check_eq("clr_sum", sum_a, 28);
    end
    clear_i = 1'b0;
    idle_clear();

    // Asynchronous reset mid-window discards everything in flight.
    for (int c = 0; c < 2; c++) begin
      in_valid_i = 1'b1;
      step();
    end
    in_valid_i = 1'b0;
    rst_ni = 1'b0;
    #2;
    check_eq("mrst_sum_a", sum_a, 0);
    check_eq("mrst_valid_a", valid_a, 0);
    check_eq("mrst_sum_b", sum_b, 0);
    check_eq("mrst_sum_d", sum_d, 0);
    #1 rst_ni = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      check_eq("mrst_no_stale", valid_a, 0);
    end
    for (int c = 0; c < 10; c++) begin
      in_valid_i = (c < 4);
      step();
      check_eq("mrst_win_valid", valid_a, (c + 1 == 8));
      if (c + 1 == 8) check_eq("mrst_win_sum", sum_a, 28);
    end
    idle_clear();

    // Narrow output: true sum 2097088 saturates or wraps to -64.
    set_all(16'd32767);
    for (int c = 0; c < 10; c++) begin
      in_valid_i = (c < 4);
      step();
      check_eq("narrow_valid", valid_d, (c + 1 == 8));
`ifdef SUM_TREE_SAT_EN
      check_eq("narrow_sat", sat_d, (c + 1 == 8));
      if (c + 1 == 8) check_eq("narrow_sum", sum_d, 32767);
`else
      if (c + 1 == 8) check_eq("narrow_sum", sum_d, -64);
`endif
    end
    in_valid_i = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
